// File: rtl/sram512x8_bist.sv
// sram512x8_bist - March C- built-in self test controller for a single-port
// SRAM macro (CEN/GWEN/WEN active-low, read data valid the cycle after the
// read command).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           single-cycle run request, honoured only when idle
//   busy            test in progress
//   done            result valid, held until the next accepted start
//   fail            at least one mismatch seen during the last run
//   fail_addr/data  address and read value of the first mismatch
//   fail_elem       march element (0-5) of the first mismatch
//   sram_cen/gwen/wen/a/d   registered macro command
//   sram_q          macro read data
//
// state | meaning
// IDLE  | waiting for start, macro deselected
// M0    | up   (w0)
// M1    | up   (r0, w1)
// M2    | up   (r1, w0)
// M3    | down (r0, w1)
// M4    | down (r1, w0)
// M5    | up   (r0)
// FLUSH | compare the final M5 read, then back to IDLE
module sram512x8_bist #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] BG = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] M0    = 3'd1;
  localparam logic [2:0] M1    = 3'd2;
  localparam logic [2:0] M2    = 3'd3;
  localparam logic [2:0] M3    = 3'd4;
  localparam logic [2:0] M4    = 3'd5;
  localparam logic [2:0] M5    = 3'd6;
  localparam logic [2:0] FLUSH = 3'd7;

  localparam logic [ADDR_W-1:0] A_MAX = '1;
  localparam logic [ADDR_W-1:0] A_ONE = 1;

  // state/addr/ph describe the command currently on the sram_* pins
  logic [2:0]        state, nxt_state;
  logic [ADDR_W-1:0] addr, nxt_addr;
  logic              ph, nxt_ph;
  logic              pair, down, at_end, accept;
  logic              nxt_op, nxt_rd, nxt_wr;
  logic [DATA_W-1:0] nxt_wdata, nxt_exp;

  // expected value of the read on the pins, and its copy one cycle later
  // when sram_q is valid
  logic [DATA_W-1:0] cur_exp, chk_exp;
  logic [2:0]        cur_elem, chk_elem;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_vld, mismatch;

  assign pair     = (state == M1) || (state == M2) || (state == M3) || (state == M4);
  assign down     = (state == M3) || (state == M4);
  assign at_end   = down ? (addr == '0) : (addr == A_MAX);
  assign accept   = (state == IDLE) && start;
  assign mismatch = chk_vld && (sram_q != chk_exp);

  always_comb begin
    nxt_state = state;
    nxt_addr  = addr;
    nxt_ph    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state = M0;
          nxt_addr  = '0;
        end
      end
      FLUSH: begin
        nxt_state = IDLE;
        nxt_addr  = '0;
      end
      default: begin
        if (pair && !ph) begin
          // second half of a read/write pair stays on the same address
          nxt_ph = 1'b1;
        end else if (at_end) begin
          nxt_state = state + 3'd1;
          nxt_addr  = ((nxt_state == M3) || (nxt_state == M4)) ? A_MAX : '0;
        end else begin
          nxt_addr = down ? (addr - A_ONE) : (addr + A_ONE);
        end
      end
    endcase
  end

  always_comb begin
    nxt_op    = (nxt_state != IDLE) && (nxt_state != FLUSH);
    nxt_rd    = nxt_op && ((nxt_state == M5) || ((nxt_state != M0) && !nxt_ph));
    nxt_wr    = nxt_op && !nxt_rd;
    nxt_wdata = ((nxt_state == M1) || (nxt_state == M3)) ? ~BG : BG;
    nxt_exp   = ((nxt_state == M2) || (nxt_state == M4)) ? ~BG : BG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      ph        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= '0;
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
      cur_exp   <= '0;
      cur_elem  <= '0;
      chk_vld   <= 1'b0;
      chk_exp   <= '0;
      chk_addr  <= '0;
      chk_elem  <= '0;
    end else begin
      state     <= nxt_state;
      addr      <= nxt_addr;
      ph        <= nxt_ph;
      busy      <= (nxt_state != IDLE);
      sram_cen  <= ~nxt_op;
      sram_gwen <= ~nxt_wr;
      sram_wen  <= nxt_wr ? '0 : '1;
      sram_a    <= nxt_op ? nxt_addr : '0;
      sram_d    <= nxt_wr ? nxt_wdata : '0;
      cur_exp   <= nxt_exp;
      cur_elem  <= nxt_state - 3'd1;
      chk_vld   <= ~sram_cen & sram_gwen;
      chk_exp   <= cur_exp;
      chk_addr  <= sram_a;
      chk_elem  <= cur_elem;
      if (accept) begin
        done      <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_elem <= '0;
      end else begin
        if (state == FLUSH) done <= 1'b1;
        if (mismatch && !fail) begin
          fail      <= 1'b1;
          fail_addr <= chk_addr;
          fail_data <= sram_q;
          fail_elem <= chk_elem;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram512x8_bist.sv
module tb_sram512x8_bist;
  localparam int N = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, fail;
  logic [8:0] fail_addr;
  logic [7:0] fail_data;
  logic [2:0] fail_elem;
  logic       sram_cen, sram_gwen;
  logic [7:0] sram_wen, sram_d;
  logic [8:0] sram_a;
  logic [7:0] sram_q = 8'h00;

  int checks = 0;
  int failures = 0;

  sram512x8_bist #(.ADDR_W(9), .DATA_W(8), .BG(8'h55)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_elem(fail_elem),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  // macro model with per-address stuck-at masks applied on read
  logic [7:0] mem [0:N-1];
  logic [7:0] sa1 [0:N-1];
  logic [7:0] sa0 [0:N-1];
  int total_ops = 0, total_wr = 0, total_rd = 0;
  logic [8:0] tr_addr [0:16383];
  logic       tr_wr   [0:16383];

  always @(posedge clk) begin
    if (!sram_cen) begin
      tr_addr[total_ops % 16384] = sram_a;
      tr_wr[total_ops % 16384]   = !sram_gwen;
      total_ops++;
      if (!sram_gwen) begin
        total_wr++;
        mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      end else begin
        total_rd++;
        sram_q <= (mem[sram_a] | sa1[sram_a]) & ~sa0[sram_a];
      end
    end
  end

  typedef struct {
    logic [8:0] fa1; logic [7:0] f1s1; logic [7:0] f1s0;
    logic [8:0] fa2; logic [7:0] f2s1; logic [7:0] f2s0;
    logic       e_fail; logic [8:0] e_addr; logic [7:0] e_data; logic [2:0] e_elem;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_faults(input vec_t v);
    for (int i = 0; i < N; i++) begin
      sa1[i] = 8'h00;
      sa0[i] = 8'h00;
    end
    sa1[v.fa1] = sa1[v.fa1] | v.f1s1;
    sa0[v.fa1] = sa0[v.fa1] | v.f1s0;
    sa1[v.fa2] = sa1[v.fa2] | v.f2s1;
    sa0[v.fa2] = sa0[v.fa2] | v.f2s0;
  endtask

  // start pulse, then count busy cycles; optional extra start at busy cycle
  // pulse_at, optional early exit at busy cycle abort_at
  task automatic run(input int pulse_at, input int abort_at, output int cyc, output logic clr_ok);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr_ok = !fail && !done && (fail_addr == 9'h0) && (fail_data == 8'h0) && (fail_elem == 3'h0);
    cyc = 0;
    while (busy && cyc < 20000 && !(abort_at != 0 && cyc == abort_at)) begin
      cyc++;
      start = (cyc == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc, base, w0, r0, errs, snap;
    logic clr_ok;
    vecs[0] = '{9'h000, 8'h00, 8'h00, 9'h000, 8'h00, 8'h00, 1'b0, 9'h000, 8'h00, 3'd0};
    vecs[1] = '{9'h1A3, 8'h04, 8'h00, 9'h000, 8'h00, 8'h00, 1'b1, 9'h1A3, 8'hAE, 3'd2};
    vecs[2] = '{9'h010, 8'h00, 8'h01, 9'h020, 8'h00, 8'h01, 1'b1, 9'h010, 8'h54, 3'd1};
    vecs[3] = '{9'h1FF, 8'h00, 8'h02, 9'h000, 8'h00, 8'h00, 1'b1, 9'h1FF, 8'hA8, 3'd2};
    vecs[4] = '{9'h000, 8'h80, 8'h00, 9'h000, 8'h00, 8'h00, 1'b1, 9'h000, 8'hD5, 3'd1};
    vecs[5] = '{9'h000, 8'h00, 8'h00, 9'h000, 8'h00, 8'h00, 1'b0, 9'h000, 8'h00, 3'd0};

    repeat (3) @(negedge clk);
    chk("reset_status", {busy, done, fail, fail_addr, fail_data, fail_elem}, 32'h0);
    chk("reset_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {1'b1, 1'b1, 8'hFF, 9'h0, 8'h0});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      set_faults(vecs[v]);
      base = total_ops; w0 = total_wr; r0 = total_rd;
      run(0, 0, cyc, clr_ok);
      chk($sformatf("v%0d_clear_on_start", v), clr_ok, 1);
      chk($sformatf("v%0d_busy_cycles", v), cyc, 10 * N + 1);
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_fail", v), fail, vecs[v].e_fail);
      chk($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].e_addr);
      chk($sformatf("v%0d_fail_data", v), fail_data, vecs[v].e_data);
      chk($sformatf("v%0d_fail_elem", v), fail_elem, vecs[v].e_elem);
      chk($sformatf("v%0d_writes", v), total_wr - w0, 5 * N);
      chk($sformatf("v%0d_reads", v), total_rd - r0, 5 * N);
      if (v == 0) begin
        errs = 0;
        for (int i = 0; i < N; i++) begin
          if (tr_addr[(base + i) % 16384] != 9'(i) || !tr_wr[(base + i) % 16384]) errs++;
          for (int e = 0; e < 2; e++) begin
            if (tr_addr[(base + N + 2*N*e + 2*i) % 16384] != 9'(i) || tr_wr[(base + N + 2*N*e + 2*i) % 16384]) errs++;
            if (tr_addr[(base + N + 2*N*e + 2*i + 1) % 16384] != 9'(i) || !tr_wr[(base + N + 2*N*e + 2*i + 1) % 16384]) errs++;
          end
          if (tr_addr[(base + 9*N + i) % 16384] != 9'(i) || tr_wr[(base + 9*N + i) % 16384]) errs++;
        end
        chk("trace_up_elements_errs", errs, 0);
        errs = 0;
        for (int e = 0; e < 2; e++) begin
          for (int i = 0; i < N; i++) begin
            if (tr_addr[(base + 5*N + 2*N*e + 2*i) % 16384] != 9'(N - 1 - i) || tr_wr[(base + 5*N + 2*N*e + 2*i) % 16384]) errs++;
            if (tr_addr[(base + 5*N + 2*N*e + 2*i + 1) % 16384] != 9'(N - 1 - i) || !tr_wr[(base + 5*N + 2*N*e + 2*i + 1) % 16384]) errs++;
          end
        end
        chk("trace_down_elements_errs", errs, 0);
        chk("ops_total", total_ops - base, 10 * N);
        chk("idle_pins_after_done", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {1'b1, 1'b1, 8'hFF, 9'h0, 8'h0});
      end
    end

    // start pulsed while busy is ignored
    set_faults(vecs[0]);
    run(100, 0, cyc, clr_ok);
    chk("start_during_busy_cycles", cyc, 10 * N + 1);
    chk("start_during_busy_done", {done, fail}, 2'b10);
    repeat (3) @(negedge clk);
    chk("no_restart_after_done", busy, 0);

    // reset in the middle of a run
    run(0, 1000, cyc, clr_ok);
    chk("abort_reached_cycle", cyc, 1000);
    rst = 1'b1;
    #1;
    chk("abort_cen", sram_cen, 1);
    chk("abort_status", {busy, done, fail, fail_addr, fail_data, fail_elem}, 32'h0);
    chk("abort_pins", {sram_gwen, sram_wen, sram_a, sram_d}, {1'b1, 8'hFF, 9'h0, 8'h0});
    snap = total_ops;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_access", total_ops - snap, 0);
    chk("abort_stays_idle", busy, 0);
    run(0, 0, cyc, clr_ok);
    chk("after_abort_cycles", cyc, 10 * N + 1);
    chk("after_abort_result", {done, fail}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
